// File: rtl/ula_issue_stage.sv
// Operand-issue and writeback stage in front of a 32-bit ALU with a 32x32 register bank.
// Latency: accept edge -> LOAD -> EXEC -> WB, so the bank write lands 3 cycles after accept; one instruction per 4 cycles.
// Backpressure: in_ready is high only in IDLE; in_valid outside IDLE is ignored and must be held by upstream.
module ula_issue_stage #(
    parameter int         DATA_W  = 32,
    parameter int         IMM_W   = 16,
    parameter logic [4:0] IDLE_OP = 5'b00111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_ra,
    input  logic [4:0]        in_rb,
    input  logic              in_imm_en,
    input  logic [IMM_W-1:0]  in_imm,
    output logic [DATA_W-1:0] ula_A,
    output logic [DATA_W-1:0] ula_B,
    output logic [4:0]        ula_opcode,
    input  logic [DATA_W-1:0] ula_Out,
    input  logic              ula_Flag,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_q,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_WB} state_t;

    state_t            state;
    logic [DATA_W-1:0] bank [32];
    logic [4:0]        rd_q;
    logic [4:0]        op_q;
    logic              illegal_q;
    logic              flag_cap;
    logic [DATA_W-1:0] imm_ext;
    logic              accept;

    // Opcodes the ALU does not implement; the idle parking code is among them.
    function automatic logic is_illegal(input logic [4:0] op);
        return (op == 5'b00010) || (op == 5'b00111) ||
               ((op >= 5'b01010) && (op <= 5'b01111));
    endfunction

    assign imm_ext  = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    assign in_ready = (state == S_IDLE);
    assign accept   = in_ready && in_valid;

    // Issue FSM, register bank and all registered outputs; bank[0] is never written so it reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            for (int i = 0; i < 32; i++) bank[i] <= '0;
            ula_A      <= '0;
            ula_B      <= '0;
            ula_opcode <= IDLE_OP;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            flag_q     <= 1'b0;
            err        <= 1'b0;
            rd_q       <= '0;
            op_q       <= IDLE_OP;
            illegal_q  <= 1'b0;
            flag_cap   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ula_A     <= bank[in_ra];
                        ula_B     <= in_imm_en ? imm_ext : bank[in_rb];
                        rd_q      <= in_rd;
                        op_q      <= in_opcode;
                        illegal_q <= is_illegal(in_opcode);
                        // err is raised at accept so its pulse occupies the LOAD cycle
                        err       <= is_illegal(in_opcode);
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (illegal_q) begin
                        state <= S_IDLE;
                    end else begin
                        ula_opcode <= op_q;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wb_data    <= ula_Out;
                    wb_rd      <= rd_q;
                    flag_cap   <= ula_Flag;
                    wb_valid   <= 1'b1;
                    // park on the idle code so an identical next opcode is seen as a change
                    ula_opcode <= IDLE_OP;
                    state      <= S_WB;
                end
                S_WB: begin
                    if (rd_q != 5'd0) bank[rd_q] <= wb_data;
                    flag_q <= flag_cap;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_issue_stage.sv
// Self-checking bench for ula_issue_stage with an opcode-change-triggered ALU model.
// Expected writebacks come from a register-file model and a queue; literal checks pin key results.
// Instructions are issued one at a time through in_valid/in_ready.
module tb_ula_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode, in_rd, in_ra, in_rb;
    logic        in_imm_en;
    logic [15:0] in_imm;
    logic [31:0] ula_A, ula_B;
    logic [4:0]  ula_opcode;
    logic [31:0] ula_Out = '0;
    logic        ula_Flag = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flag_q;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [31:0] mreg [32];
    logic        mflag;
    logic [4:0]  exp_rd [$];
    logic [31:0] exp_data [$];
    logic [31:0] last_wb_data;
    logic [4:0]  last_wb_rd;

    ula_issue_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .ula_A(ula_A), .ula_B(ula_B), .ula_opcode(ula_opcode),
        .ula_Out(ula_Out), .ula_Flag(ula_Flag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flag_q(flag_q), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU semantics: add, inca, passa; carry-out as flag.
    function automatic void alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic f);
        logic [32:0] s;
        s = '0;
        r = '0;
        f = 1'b0;
        case (op)
            5'b00000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; f = s[32]; end
            5'b00011: begin s = {1'b0, a} + 33'd1;     r = s[31:0]; f = s[32]; end
            5'b10101: begin r = a; f = 1'b0; end
            default:  begin r = '0; f = 1'b0; end
        endcase
    endfunction

    // ALU stand-in: recomputes only when its opcode changes; idle/unknown codes hold the outputs.
    always @(ula_opcode) begin
        logic [31:0] r;
        logic        f;
        if (ula_opcode == 5'b00000 || ula_opcode == 5'b00011 || ula_opcode == 5'b10101) begin
            alu_ref(ula_opcode, ula_A, ula_B, r, f);
            ula_Out  = r;
            ula_Flag = f;
        end
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit op_illegal(input logic [4:0] op);
        return (op == 5'd2) || (op == 5'd7) || (op >= 5'd10 && op <= 5'd15);
    endfunction

    // Compare process: every writeback pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (exp_rd.size() == 0) begin
                chk(1'b0, "wb_unexpected", {27'd0, wb_rd}, 32'd0);
            end else begin
                logic [4:0]  erd;
                logic [31:0] edat;
                erd  = exp_rd.pop_front();
                edat = exp_data.pop_front();
                chk(wb_rd == erd, "wb_rd", {27'd0, wb_rd}, {27'd0, erd});
                chk(wb_data == edat, "wb_data", wb_data, edat);
            end
            last_wb_data = wb_data;
            last_wb_rd   = wb_rd;
        end
    end

    // Issue one instruction starting from a negedge; checks per-phase timing; returns at the next IDLE negedge.
    task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] ra,
                         input logic [4:0] rb, input logic imm_en, input logic [15:0] imm);
        int guard;
        logic [31:0] a, b, r;
        logic f, ill;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk(in_ready == 1'b1, "ready_timeout", {31'd0, in_ready}, 32'd1);
        in_opcode = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm_en = imm_en; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a   = mreg[ra];
        b   = imm_en ? {{16{imm[15]}}, imm} : mreg[rb];
        ill = op_illegal(op);
        @(negedge clk); // LOAD
        chk(ula_A == a, "load_A", ula_A, a);
        chk(ula_B == b, "load_B", ula_B, b);
        chk(ula_opcode == 5'b00111, "load_opcode_idle", {27'd0, ula_opcode}, 32'd7);
        chk(in_ready == 1'b0, "load_ready", {31'd0, in_ready}, 32'd0);
        chk(err == ill, "load_err", {31'd0, err}, {31'd0, ill});
        if (ill) begin
            @(negedge clk);
            chk(in_ready == 1'b1, "ill_ready_back", {31'd0, in_ready}, 32'd1);
            chk(err == 1'b0, "ill_err_cleared", {31'd0, err}, 32'd0);
            chk(wb_valid == 1'b0, "ill_no_wb", {31'd0, wb_valid}, 32'd0);
            chk(flag_q == mflag, "ill_flag_kept", {31'd0, flag_q}, {31'd0, mflag});
            return;
        end
        alu_ref(op, a, b, r, f);
        exp_rd.push_back(rd);
        exp_data.push_back(r);
        if (rd != 5'd0) mreg[rd] = r;
        mflag = f;
        @(negedge clk); // EXEC
        chk(ula_opcode == op, "exec_opcode", {27'd0, ula_opcode}, {27'd0, op});
        chk(wb_valid == 1'b0, "exec_no_wb", {31'd0, wb_valid}, 32'd0);
        @(negedge clk); // WB
        chk(wb_valid == 1'b1, "wb_pulse", {31'd0, wb_valid}, 32'd1);
        chk(ula_opcode == 5'b00111, "wb_opcode_parked", {27'd0, ula_opcode}, 32'd7);
        @(negedge clk); // IDLE
        chk(wb_valid == 1'b0, "wb_one_cycle", {31'd0, wb_valid}, 32'd0);
        chk(in_ready == 1'b1, "idle_ready", {31'd0, in_ready}, 32'd1);
        chk(flag_q == mflag, "flag_q", {31'd0, flag_q}, {31'd0, mflag});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mflag = 1'b0;
        exp_rd.delete();
        exp_data.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        reset = 1'b1;
        in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_ra = '0; in_rb = '0;
        in_imm_en = 1'b0; in_imm = '0;
        last_wb_data = '0; last_wb_rd = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(ula_A == 0, "rst_A", ula_A, 0);
        chk(ula_B == 0, "rst_B", ula_B, 0);
        chk(ula_opcode == 5'b00111, "rst_opcode", {27'd0, ula_opcode}, 32'd7);
        chk(wb_valid == 0, "rst_wb_valid", {31'd0, wb_valid}, 0);
        chk(wb_rd == 0, "rst_wb_rd", {27'd0, wb_rd}, 0);
        chk(wb_data == 0, "rst_wb_data", wb_data, 0);
        chk(flag_q == 0, "rst_flag_q", {31'd0, flag_q}, 0);
        chk(err == 0, "rst_err", {31'd0, err}, 0);
        chk(in_ready == 1, "rst_ready", {31'd0, in_ready}, 1);
        reset = 1'b0;
        @(negedge clk);

        // r1 = r0 + 5
        issue(5'b00000, 5'd1, 5'd0, 5'd0, 1'b1, 16'h0005);
        chk(last_wb_rd == 5'd1, "lit_r1_rd", {27'd0, last_wb_rd}, 32'd1);
        chk(last_wb_data == 32'd5, "lit_r1", last_wb_data, 32'd5);

        // back-to-back identical adds: r2 = r1+r1, r3 = r2+r1
        issue(5'b00000, 5'd2, 5'd1, 5'd1, 1'b0, 16'h0);
        a1 = acc_cyc;
        chk(last_wb_data == 32'd10, "lit_r2", last_wb_data, 32'd10);
        issue(5'b00000, 5'd3, 5'd2, 5'd1, 1'b0, 16'h0);
        chk(acc_cyc - a1 == 4, "accept_spacing", acc_cyc - a1, 32'd4);
        chk(last_wb_data == 32'd15, "lit_r3", last_wb_data, 32'd15);

        // sign-extended immediate then dependent inca wraps to 0 with carry
        issue(5'b00000, 5'd4, 5'd0, 5'd0, 1'b1, 16'hFFFF);
        chk(last_wb_data == 32'hFFFF_FFFF, "lit_r4", last_wb_data, 32'hFFFF_FFFF);
        issue(5'b00011, 5'd5, 5'd4, 5'd0, 1'b0, 16'h0);
        chk(last_wb_data == 32'd0, "lit_r5", last_wb_data, 32'd0);
        chk(flag_q == 1'b1, "lit_flag_carry", {31'd0, flag_q}, 32'd1);

        // write to r0 is reported but discarded
        issue(5'b00000, 5'd0, 5'd1, 5'd0, 1'b1, 16'h0003);
        chk(last_wb_rd == 5'd0, "lit_r0_rd", {27'd0, last_wb_rd}, 32'd0);
        chk(last_wb_data == 32'd8, "lit_r0_data", last_wb_data, 32'd8);
        issue(5'b10101, 5'd8, 5'd0, 5'd0, 1'b0, 16'h0);
        chk(last_wb_data == 32'd0, "lit_r0_reads_0", last_wb_data, 32'd0);

        // illegal opcode: err, no write, bank untouched
        issue(5'b01100, 5'd9, 5'd1, 5'd0, 1'b1, 16'h0001);
        issue(5'b10101, 5'd10, 5'd9, 5'd0, 1'b0, 16'h0);
        chk(last_wb_data == 32'd0, "lit_r9_unwritten", last_wb_data, 32'd0);
        issue(5'b10101, 5'd11, 5'd1, 5'd0, 1'b0, 16'h0);
        chk(last_wb_data == 32'd5, "lit_r1_kept", last_wb_data, 32'd5);

        // reset during EXEC of r6 = 7
        in_opcode = 5'b00000; in_rd = 5'd6; in_ra = 5'd0; in_rb = 5'd0; in_imm_en = 1'b1; in_imm = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk); // LOAD
        @(negedge clk); // EXEC
        chk(ula_opcode == 5'b00000, "abort_exec_opcode", {27'd0, ula_opcode}, 32'd0);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk(wb_valid == 1'b0, "abort_no_wb", {31'd0, wb_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk(ula_opcode == 5'b00111, "abort_opcode_idle", {27'd0, ula_opcode}, 32'd7);
        chk(in_ready == 1'b1, "abort_ready", {31'd0, in_ready}, 32'd1);
        chk(wb_valid == 1'b0, "abort_still_no_wb", {31'd0, wb_valid}, 32'd0);
        issue(5'b10101, 5'd12, 5'd6, 5'd0, 1'b0, 16'h0);
        chk(last_wb_data == 32'd0, "lit_r6_zero", last_wb_data, 32'd0);
        issue(5'b10101, 5'd13, 5'd1, 5'd0, 1'b0, 16'h0);
        chk(last_wb_data == 32'd0, "lit_r1_cleared", last_wb_data, 32'd0);

        repeat (4) @(negedge clk);
        chk(exp_rd.size() == 0, "queue_drained", exp_rd.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
